// File: rtl/light_sequencer.sv
// light_sequencer: timed traffic-light FSM with a latched pedestrian WALK/CLEAR insertion
module light_sequencer #(
  parameter int C_CLK_FRQ      = 100000000,
  parameter int C_GREEN_MS     = 5000,
  parameter int C_MIN_GREEN_MS = 2000,
  parameter int C_YELLOW_MS    = 1000,
  parameter int C_RED_MS       = 3000,
  parameter int C_WALK_MS      = 4000,
  parameter int C_CLEAR_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] inPedestrian,
  output logic [1:0] outLight,
  output logic [2:0] outState,
  output logic       outPending,
  output logic       outPedAck
);
  typedef enum logic [2:0] {RED = 3'd0, GREEN = 3'd1, YELLOW = 3'd2, WALK = 3'd3, CLEAR = 3'd4} state_t;
  localparam logic [31:0] P    = 32'(C_CLK_FRQ / 1000);
  localparam logic [16:0] D_G  = 17'(C_GREEN_MS);
  localparam logic [16:0] D_MG = 17'(C_MIN_GREEN_MS);
  localparam logic [16:0] D_Y  = 17'(C_YELLOW_MS);
  localparam logic [16:0] D_R  = 17'(C_RED_MS);
  localparam logic [16:0] D_W  = 17'(C_WALK_MS);
  localparam logic [16:0] D_C  = 17'(C_CLEAR_MS);
  state_t state, nxt;
  logic [31:0] pre;
  logic [15:0] msCnt;
  logic [16:0] el;
  logic btnPrev, btn, tick;
  always_comb begin
    btn  = |inPedestrian;
    tick = pre == P - 32'd1;
    el   = {1'b0, msCnt} + 17'd1;
    nxt  = state;
    case (state)
      RED:     nxt = tick && el == D_R ? (outPending ? WALK : GREEN) : RED;
      GREEN:   nxt = tick && (el == D_G || (outPending && el >= D_MG)) ? YELLOW : GREEN;
      YELLOW:  nxt = tick && el == D_Y ? RED : YELLOW;
      WALK:    nxt = tick && el == D_W ? CLEAR : WALK;
      CLEAR:   nxt = tick && el == D_C ? GREEN : CLEAR;
      default: nxt = RED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RED;
      pre        <= '0;
      msCnt      <= '0;
      btnPrev    <= 1'b0;
      outPending <= 1'b0;
      outPedAck  <= 1'b0;
      outLight   <= 2'b00;
      outState   <= 3'd0;
    end else begin
      state      <= nxt;
      btnPrev    <= btn;
      pre        <= nxt != state || tick ? '0 : pre + 32'd1;
      msCnt      <= nxt != state ? '0 : tick ? msCnt + 16'd1 : msCnt;
      // entering or staying in WALK swallows any edge, so clearing wins
      outPending <= nxt != WALK && (outPending || (btn && !btnPrev));
      outPedAck  <= nxt == WALK && state != WALK;
      outLight   <= nxt == GREEN ? 2'b01 : nxt == YELLOW ? 2'b10 : nxt == WALK ? 2'b11 : 2'b00;
      outState   <= nxt;
    end
  end
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed phase-length scenarios plus random buttons/resets against a cycle-count model
module tb_light_sequencer;
  localparam int P = 10, G = 5, MG = 2, Y = 2, R = 3, W = 4, C = 1;
  logic clk = 0, rst = 1;
  logic [1:0] inPedestrian = 0;
  logic [1:0] outLight;
  logic [2:0] outState;
  logic outPending, outPedAck;
  int nCmp = 0, nErr = 0;
  int mState, mCnt, mEl, mNx;
  bit mPend, mPrev, mAck;
  int lightOf[5] = '{0, 1, 2, 3, 0};
  light_sequencer #(
    .C_CLK_FRQ(10000), .C_GREEN_MS(G), .C_MIN_GREEN_MS(MG), .C_YELLOW_MS(Y),
    .C_RED_MS(R), .C_WALK_MS(W), .C_CLEAR_MS(C)
  ) dut (
    .clk(clk), .rst(rst), .inPedestrian(inPedestrian), .outLight(outLight),
    .outState(outState), .outPending(outPending), .outPedAck(outPedAck)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    nCmp++;
    if (got != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int durOf(input int s);
    return s == 0 ? R : s == 1 ? G : s == 2 ? Y : s == 3 ? W : C;
  endfunction
  task automatic modelStep(input logic [1:0] p, input bit r);
    bit btn;
    if (r) begin
      mState = 0; mCnt = 0; mPend = 0; mPrev = 0; mAck = 0;
      return;
    end
    btn = |p;
    mNx = mState;
    mEl = (mCnt + 1) / P;
    if ((mCnt + 1) % P == 0) begin
      if (mState == 1) begin
        if (mEl == G || (mPend && mEl >= MG)) mNx = 2;
      end else if (mEl == durOf(mState)) begin
        mNx = mState == 0 ? (mPend ? 3 : 1) : mState == 2 ? 0 : mState == 3 ? 4 : 1;
      end
    end
    mAck = mNx == 3 && mState != 3;
    mPend = mNx != 3 && (mPend || (btn && !mPrev));
    mPrev = btn;
    mCnt = mNx != mState ? 0 : mCnt + 1;
    mState = mNx;
  endtask
  task automatic step(input logic [1:0] p, input bit r);
    inPedestrian = p;
    rst = r;
    @(posedge clk);
    modelStep(p, r);
    @(negedge clk);
    check("state", outState, mState);
    check("light", outLight, lightOf[mState]);
    check("pending", outPending, mPend);
    check("pedAck", outPedAck, mAck);
  endtask
  task automatic measure(input logic [1:0] pat, input int from, input int to, output int len);
    int s;
    s = outState;
    len = 1;
    for (int i = 0; i < 1000; i++) begin
      step((len - 1) >= from && (len - 1) <= to ? pat : 2'b00, 0);
      if (outState != s) return;
      len++;
    end
    check("timeout", 1, 0);
  endtask
  task automatic expectPhase(input string tag, input logic [1:0] pat, input int from, input int to, input int exp);
    int len;
    measure(pat, from, to, len);
    check(tag, len, exp);
  endtask
  initial begin
    logic [1:0] ped;
    @(negedge clk);
    step(0, 1);
    step(0, 1);
    check("rstState", outState, 0);
    check("rstLight", outLight, 0);
    check("rstPend", outPending, 0);
    expectPhase("t1Red", 0, 0, -1, 30);
    expectPhase("t1Green", 0, 0, -1, 50);
    expectPhase("t1Yellow", 0, 0, -1, 20);
    expectPhase("t1Red2", 0, 0, -1, 30);
    check("t1Next", outLight, 1);
    expectPhase("t2Green", 2'b01, 5, 5, 20);
    expectPhase("t2Yellow", 0, 0, -1, 20);
    expectPhase("t2Red", 0, 0, -1, 30);
    check("t2WalkLight", outLight, 3);
    check("t2Ack", outPedAck, 1);
    expectPhase("t2Walk", 0, 0, -1, 40);
    expectPhase("t2Clear", 0, 0, -1, 10);
    check("t2Next", outState, 1);
    expectPhase("t3Green", 2'b01, 35, 35, 40);
    expectPhase("t3Yellow", 0, 0, -1, 20);
    expectPhase("t3Red", 0, 0, -1, 30);
    expectPhase("t3Walk", 0, 0, -1, 40);
    expectPhase("t3Clear", 0, 0, -1, 10);
    expectPhase("t4Green", 0, 0, -1, 50);
    expectPhase("t4Yellow", 2'b11, 0, 999, 20);
    expectPhase("t4Red", 2'b11, 0, 999, 30);
    check("t4Walk", outState, 3);
    expectPhase("t4WalkLen", 2'b01, 20, 22, 40);
    expectPhase("t4Clear", 0, 0, -1, 10);
    check("t4Pend", outPending, 0);
    expectPhase("t5Green", 2'b10, 1, 1, 20);
    expectPhase("t5Yellow", 0, 0, -1, 20);
    expectPhase("t5Red", 0, 0, -1, 30);
    for (int i = 0; i < 15; i++) step(0, 0);
    step(0, 1);
    check("t5State", outState, 0);
    check("t5Light", outLight, 0);
    check("t5Pend", outPending, 0);
    expectPhase("t5RedLen", 0, 0, -1, 30);
    check("t5Next", outState, 1);
    expectPhase("t6Green", 0, 0, -1, 50);
    expectPhase("t6Yellow", 0, 0, -1, 20);
    expectPhase("t6Red", 2'b01, 10, 10, 30);
    check("t6Walk", outState, 3);
    check("t6Ack", outPedAck, 1);
    ped = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 39) == 0) ped = 2'($urandom_range(0, 3));
      step(ped, $urandom_range(0, 1999) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
